pwm_multichannel: RTL and testbench

- Parametrised successor to the single-duty PWM peripheral. Drives NUM_CH outputs; every channel has its own duty value.
- Adds a programmable clock prescaler and double-buffered duty registers. Duty writes take effect only at a period boundary, so no output ever sees a glitched or truncated pulse.
- Sits between the SPI register interface and the IO pads. It takes per-channel enable masks and duty write strobes, and drives the pad output bus.

---
 rtl/pwm_multichannel_if.sv | 41 ++++
 rtl/pwm_multichannel.sv | 96 +++++++++
 tb/tb_pwm_multichannel.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multichannel_if.sv
// Register-side control bus and pad-side output bus of the multichannel PWM.
// The master drives enables, prescaler and duty writes; the slave (the PWM
// block) drives the pad outputs and the period marker.
interface pwm_multichannel_if #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 12
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic [PRE_W-1:0]  prescale;
  logic              duty_wr_en;
  logic [CH_W-1:0]   duty_wr_ch;
  logic [CNT_W-1:0]  duty_wr_data;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  modport master (
    output en_out,
    output en_pwm,
    output prescale,
    output duty_wr_en,
    output duty_wr_ch,
    output duty_wr_data,
    input  out,
    input  period_start
  );

  modport slave (
    input  en_out,
    input  en_pwm,
    input  prescale,
    input  duty_wr_en,
    input  duty_wr_ch,
    input  duty_wr_data,
    output out,
    output period_start
  );
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM with a shared prescaled period counter and double-buffered
// per-channel duty registers. Duty writes land in a shadow copy and are moved
// into the active copy only at the period boundary, so a running pulse is never
// cut short or stretched by a write.
module pwm_multichannel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  pwm_multichannel_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PRE_W-1:0]  pre_cnt_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  shadow_duty_reg [NUM_CH];
  logic [CNT_W-1:0]  active_duty_reg [NUM_CH];
  logic [NUM_CH-1:0] out_reg;
  logic [NUM_CH-1:0] out_next;
  logic              boundary_d1_reg;
  logic              period_start_reg;

  logic tick;
  logic boundary;
  logic wr_valid;

  // The >= compare means a prescale lowered below the running pre_cnt ticks
  // on the very next cycle instead of waiting for the counter to wrap.
  assign tick     = (pre_cnt_reg >= bus.prescale);
  assign boundary = tick && (cnt_reg == CNT_MAX);

  // Indices beyond the last channel are dropped rather than aliased.
  assign wr_valid = bus.duty_wr_en && (32'(bus.duty_wr_ch) < 32'(NUM_CH));

  // Prescaler and period counter; cnt wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_reg <= '0;
      cnt_reg     <= '0;
    end else if (tick) begin
      pre_cnt_reg <= '0;
      cnt_reg     <= cnt_reg + CNT_W'(1);
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
    end
  end

  // Shadow/active duty pair. The boundary copy reads the shadow value from
  // before this edge, so a write in the boundary cycle waits one more period.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_duty_reg[i] <= '0;
        active_duty_reg[i] <= '0;
      end
    end else begin
      if (boundary) begin
        for (int i = 0; i < NUM_CH; i++) begin
          active_duty_reg[i] <= shadow_duty_reg[i];
        end
      end
      if (wr_valid) begin
        shadow_duty_reg[bus.duty_wr_ch] <= bus.duty_wr_data;
      end
    end
  end

  // Per-channel output decision: output enable dominates, then static-high
  // when PWM is disabled, then full-scale duty as 100%, else compare.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign out_next[gi] = !bus.en_out[gi]                ? 1'b0 :
                          !bus.en_pwm[gi]                ? 1'b1 :
                          (active_duty_reg[gi] == CNT_MAX) ? 1'b1 :
                          (cnt_reg < active_duty_reg[gi]);
  end

  // Registered pad outputs and the two-stage period marker, which lines up
  // with the first output cycle computed from cnt=0 and the new duties.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg          <= '0;
      boundary_d1_reg  <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      out_reg          <= out_next;
      boundary_d1_reg  <= boundary;
      period_start_reg <= boundary_d1_reg;
    end
  end

  assign bus.out          = out_reg;
  assign bus.period_start = period_start_reg;
endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: an integer-level model of period
// position, duty buffers and enables is checked against the DUT every cycle,
// and hand-computed pulse widths / period spacings pin the model.
module tb_pwm_multichannel;
  localparam int NUM_CH = 12;
  localparam int CNT_W  = 8;
  localparam int PRE_W  = 12;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PERIOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pwm_multichannel_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

  pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: position inside the prescale interval, position inside the
  // period, duty buffers as plain integers, and expected outputs after an edge.
  int                m_phase;
  int                m_cnt;
  int                m_shadow [NUM_CH];
  int                m_active [NUM_CH];
  logic [NUM_CH-1:0] m_out;
  logic [NUM_CH-1:0] m_nxt;
  logic              m_ps;
  logic              m_bd1;
  bit                m_tick;
  bit                m_bnd;

  int hi_cnt   [NUM_CH];
  int first_lo [NUM_CH];

  // Model update at every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0;
        m_cnt   = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          m_shadow[c] = 0;
          m_active[c] = 0;
        end
        m_out = '0;
        m_ps  = 1'b0;
        m_bd1 = 1'b0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (!bus.en_out[c])                m_nxt[c] = 1'b0;
          else if (!bus.en_pwm[c])           m_nxt[c] = 1'b1;
          else if (m_active[c] == PERIOD-1)  m_nxt[c] = 1'b1;
          else                               m_nxt[c] = (m_cnt < m_active[c]);
        end
        m_tick = (m_phase >= int'(bus.prescale));
        m_bnd  = m_tick && (m_cnt == PERIOD - 1);
        m_ps   = m_bd1;
        m_bd1  = m_bnd;
        if (m_bnd) m_active = m_shadow;
        if (bus.duty_wr_en && int'(bus.duty_wr_ch) < NUM_CH)
          m_shadow[bus.duty_wr_ch] = int'(bus.duty_wr_data);
        if (m_tick) begin
          m_phase = 0;
          m_cnt   = (m_cnt + 1) % PERIOD;
        end else begin
          m_phase = m_phase + 1;
        end
        m_out = m_nxt;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      tests++;
      if (bus.out !== m_out) begin
        fails++;
        $display("FAIL cycle_out t=%0t got %h expected %h", $time, bus.out, m_out);
      end
      tests++;
      if (bus.period_start !== m_ps) begin
        fails++;
        $display("FAIL cycle_period_start t=%0t got %b expected %b", $time, bus.period_start, m_ps);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One-cycle write strobe, launched from the current falling edge.
  task automatic write_duty(input int ch, input int data);
    bus.duty_wr_en   = 1'b1;
    bus.duty_wr_ch   = CH_W'(ch);
    bus.duty_wr_data = CNT_W'(data);
    $display("[TB] write ch=%0d data=%0d", ch, data);
    @(negedge clk);
    bus.duty_wr_en = 1'b0;
  endtask

  // Falling edges until period_start is seen; -1 when the bound expires.
  task automatic wait_ps(output int n);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (bus.period_start === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  // High-cycle count and first low sample per channel over len cycles,
  // starting with the current falling edge.
  task automatic measure(input int len);
    for (int c = 0; c < NUM_CH; c++) begin
      hi_cnt[c]   = 0;
      first_lo[c] = -1;
    end
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.out[c] === 1'b1) hi_cnt[c]++;
        else if (first_lo[c] < 0) first_lo[c] = i;
      end
    end
  endtask

  task automatic wait_model_cnt(input int target, output int ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_cnt == target) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int ok;
    int sum;
    bus.en_out       = '1;
    bus.en_pwm       = '1;
    bus.prescale     = '0;
    bus.duty_wr_en   = 1'b0;
    bus.duty_wr_ch   = '0;
    bus.duty_wr_data = '0;
    rst              = 1'b1;

    // Reset held for three edges, then the first period marker.
    $display("[TB] reset held 3 cycles");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out", int'(bus.out), 0);
      check("rst_period_start", int'(bus.period_start), 0);
    end
    rst = 1'b0;
    wait_ps(n);
    check("first_ps_edges", n, 257);
    check("first_ps_out", int'(bus.out), 0);

    // Buffered duty: mid-period writes wait for the next boundary.
    repeat (50) @(negedge clk);
    write_duty(0, 128);
    write_duty(1, 255);
    check("buf_hold", int'(bus.out[1:0]), 0);
    wait_ps(n);
    check("buf_ps_arrived", int'(n > 0), 1);
    check("buf_ps_out", int'(bus.out[1:0]), 3);
    measure(PERIOD);
    check("ch0_high", hi_cnt[0], 128);
    check("ch0_first_low", first_lo[0], 128);
    check("ch1_high", hi_cnt[1], 256);

    // Prescaler 3: period 1024 cycles, duty 64 high for 256 cycles.
    repeat (20) @(negedge clk);
    bus.prescale = PRE_W'(3);
    $display("[TB] prescale=3");
    write_duty(2, 64);
    wait_ps(n);
    check("pre3_ps_arrived", int'(n > 0), 1);
    measure(4 * PERIOD);
    check("ch2_high_pre3", hi_cnt[2], 256);
    check("ch2_first_low_pre3", first_lo[2], 256);
    wait_ps(n);
    check("pre3_spacing", n, 1);

    // Prescale lowered 100 -> 2 with pre_cnt at 50: immediate tick, then every 3.
    bus.prescale = PRE_W'(100);
    $display("[TB] prescale=100");
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_phase == 50) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("pre100_reach50", ok, 1);
    bus.prescale = PRE_W'(2);
    $display("[TB] prescale=2 at pre_cnt=50");
    @(negedge clk);
    check("pre2_tick_next", m_phase, 0);
    @(negedge clk);
    check("pre2_phase1", m_phase, 1);
    @(negedge clk);
    check("pre2_phase2", m_phase, 2);
    @(negedge clk);
    check("pre2_tick_every3", m_phase, 0);

    // Write coincident with the boundary: 10 first, then 200.
    bus.prescale = '0;
    $display("[TB] prescale=0");
    write_duty(3, 10);
    wait_model_cnt(PERIOD - 1, ok);
    check("sim_reach_boundary", ok, 1);
    write_duty(3, 200);
    wait_ps(n);
    check("sim_ps_next", n, 1);
    measure(PERIOD);
    check("ch3_high_first", hi_cnt[3], 10);
    wait_ps(n);
    check("sim_ps_following", n, 1);
    measure(PERIOD);
    check("ch3_high_second", hi_cnt[3], 200);

    // Enables: output enable off wins over duty; PWM enable off is static high.
    repeat (20) @(negedge clk);
    bus.en_out[4] = 1'b0;
    write_duty(4, 100);
    wait_ps(n);
    check("en_ps_arrived", int'(n > 0), 1);
    measure(PERIOD);
    check("ch4_disabled_high", hi_cnt[4], 0);
    check("ch2_high_pre0", hi_cnt[2], 64);
    repeat (40) @(negedge clk);
    check("ch5_before_static", int'(bus.out[5]), 0);
    bus.en_pwm[5] = 1'b0;
    @(negedge clk);
    check("ch5_static_high", int'(bus.out[5]), 1);

    // Out-of-range channel indices change no shadow register.
    write_duty(12, 77);
    write_duty(15, 200);
    wait_ps(n);
    check("oor_ps_arrived", int'(n > 0), 1);
    check("oor_ps_out", int'(bus.out), 32'h02F);
    measure(PERIOD);
    sum = 0;
    for (int c = 6; c < NUM_CH; c++) sum += hi_cnt[c];
    check("oor_idle_channels_high", sum, 0);
    check("oor_ch0_high", hi_cnt[0], 128);

    // Reset in mid-period at cnt=77 with duties loaded.
    bus.en_out = '1;
    bus.en_pwm = '1;
    wait_model_cnt(77, ok);
    check("mid_reach77", ok, 1);
    check("mid_out_before", int'(bus.out[1:0]), 3);
    rst = 1'b1;
    $display("[TB] reset at cnt=77");
    @(negedge clk);
    check("mid_rst_out", int'(bus.out), 0);
    check("mid_rst_ps", int'(bus.period_start), 0);
    rst = 1'b0;
    wait_ps(n);
    check("mid_first_ps_edges", n, 257);
    check("mid_ps_out", int'(bus.out), 0);
    measure(PERIOD);
    check("mid_ch0_high", hi_cnt[0], 0);
    check("mid_ch1_high", hi_cnt[1], 0);
    repeat (20) @(negedge clk);
    write_duty(0, 128);
    wait_ps(n);
    check("mid_rewrite_ps", int'(n > 0), 1);
    measure(PERIOD);
    check("mid_ch0_rewritten", hi_cnt[0], 128);
    check("mid_ch1_still_low", hi_cnt[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
